// File: rtl/dwt_pkg.sv
// dwt_pkg: shared types, default reconstruction taps and
// accumulator sizing for the inverse-DWT synthesis stage.
package dwt_pkg;

  localparam int DEF_COEF_W = 18;
  localparam int DEF_NTAPS  = 12;

  typedef enum logic [1:0] {
    MODE_SUM = 2'd0,
    MODE_L   = 2'd1,
    MODE_H   = 2'd2
  } mode_t;

  typedef enum logic [2:0] {
    IDLE,
    MAC_E,
    OUT_E,
    MAC_O,
    OUT_O
  } state_t;

  typedef logic signed [DEF_COEF_W-1:0] coef_t;

  localparam coef_t cL_R_DEF [DEF_NTAPS] = '{
    18'sd7309,   18'sd32415, 18'sd49226,
    18'sd20660, -18'sd14829, -18'sd8505,
    18'sd6389,   18'sd1803,  -18'sd2070,
    18'sd36,     18'sd313,   -18'sd71
  };

  localparam coef_t cH_R_DEF [DEF_NTAPS] = '{
    -18'sd71,    -18'sd314,   18'sd36,
    18'sd2069,   18'sd1803,  -18'sd6390,
    -18'sd8505,  18'sd14828,  18'sd20660,
    -18'sd49227, 18'sd32415, -18'sd7310
  };

  // Product width plus growth for NH terms plus one guard bit.
  function automatic int f_acc_w(
    input int idat_w,
    input int coef_w,
    input int ntaps
  );
    return idat_w + coef_w + $clog2(ntaps / 2) + 1;
  endfunction

endpackage

// File: rtl/dwt_synth_stage_if.sv
// dwt_synth_stage_if: sample-pair input and reconstructed
// sample output bundle of one synthesis stage.
interface dwt_synth_stage_if #(
  parameter int pIDAT_W = 18,
  parameter int pODAT_W = 20
);

  logic                      iclk_ena;
  logic                      iena;
  logic signed [pIDAT_W-1:0] idat_l;
  logic signed [pIDAT_W-1:0] idat_h;
  logic [1:0]                imode;
  logic signed [pODAT_W-1:0] odat;
  logic                      oena;
  logic                      osat;
  logic                      obusy;
  logic                      oovr;

  modport master (
    output iclk_ena, iena, idat_l, idat_h, imode,
    input  odat, oena, osat, obusy, oovr
  );

  modport slave (
    input  iclk_ena, iena, idat_l, idat_h, imode,
    output odat, oena, osat, obusy, oovr
  );

endinterface

// File: rtl/dwt_round_sat.sv
// dwt_round_sat: round-half-up by FRAC bits, then clamp
// to a signed OUT_W range with a clip flag.
module dwt_round_sat #(
  parameter int IN_W  = 41,
  parameter int FRAC  = 16,
  parameter int OUT_W = 20
) (
  input  logic signed [IN_W-1:0]  din_i,
  output logic signed [OUT_W-1:0] dout_o,
  output logic                    clip_o
);

  localparam int SH_W = IN_W + 1 - FRAC;

  localparam logic signed [IN_W:0] HALF =
    {{(IN_W + 1 - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};

  localparam logic signed [SH_W-1:0] MAXV =
    {{(SH_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};

  localparam logic signed [SH_W-1:0] MINV =
    {{(SH_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic signed [IN_W:0]   rnd;
  logic signed [SH_W-1:0] sh;
  logic                   unused_lsb;

  assign rnd        = {din_i[IN_W-1], din_i} + HALF;
  assign sh         = rnd[IN_W:FRAC];
  assign unused_lsb = ^rnd[FRAC-1:0];

  always_comb begin
    dout_o = sh[OUT_W-1:0];
    clip_o = 1'b0;
    if (sh > MAXV) begin
      dout_o = MAXV[OUT_W-1:0];
      clip_o = 1'b1;
    end else if (sh < MINV) begin
      dout_o = MINV[OUT_W-1:0];
      clip_o = 1'b1;
    end
  end

endmodule

// File: rtl/dwt_synth_stage.sv
// dwt_synth_stage: polyphase inverse-DWT stage, one MAC per
// band, two rounded/saturated outputs per accepted pair.
module dwt_synth_stage
  import dwt_pkg::*;
#(
  parameter int pIDAT_W    = 18,
  parameter int pODAT_W    = 20,
  parameter int pCOEF_W    = 18,
  parameter int pCOEF_FRAC = 16,
  parameter int pNTAPS     = 12,
  parameter logic signed [pCOEF_W-1:0] cL_R [pNTAPS] = cL_R_DEF,
  parameter logic signed [pCOEF_W-1:0] cH_R [pNTAPS] = cH_R_DEF
) (
  input logic               iclk,
  input logic               irst,
  dwt_synth_stage_if.slave  bus
);

  localparam int NH    = pNTAPS / 2;
  localparam int KW    = $clog2(NH);
  localparam int ACC_W = f_acc_w(pIDAT_W, pCOEF_W, pNTAPS);
  localparam int SUM_W = ACC_W + 1;
  localparam int PRD_W = pIDAT_W + pCOEF_W;

  typedef logic signed [pIDAT_W-1:0] smp_t;
  typedef logic signed [ACC_W-1:0]   acc_t;

  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  mode_t mode_q, mode_d;
  smp_t xl_q [NH];
  smp_t xl_d [NH];
  smp_t xh_q [NH];
  smp_t xh_d [NH];
  acc_t accl_q, accl_d;
  acc_t acch_q, acch_d;
  logic signed [pODAT_W-1:0] odat_q, odat_d;
  logic oena_q, oena_d;
  logic osat_q, osat_d;
  logic oovr_q, oovr_d;

  logic                      strobe;
  logic                      accept;
  logic                      k_last;
  logic                      ph;
  logic [KW:0]               tap;
  logic signed [PRD_W-1:0]   prod_l;
  logic signed [PRD_W-1:0]   prod_h;
  logic signed [SUM_W-1:0]   sum;
  logic signed [pODAT_W-1:0] rs_dat;
  logic                      rs_clip;

  assign strobe = bus.iclk_ena & bus.iena;
  assign accept = strobe & (state_q == IDLE);
  assign k_last = (k_q == KW'(NH - 1));
  assign ph     = (state_q == MAC_O);
  // Even phase uses taps 2k, odd phase 2k+1.
  assign tap    = {k_q, ph};
  assign prod_l = PRD_W'(cL_R[tap]) * PRD_W'(xl_q[k_q]);
  assign prod_h = PRD_W'(cH_R[tap]) * PRD_W'(xh_q[k_q]);

  always_comb begin
    unique case (mode_q)
      MODE_L:  sum = SUM_W'(accl_q);
      MODE_H:  sum = SUM_W'(acch_q);
      default: sum = SUM_W'(accl_q) + SUM_W'(acch_q);
    endcase
  end

  dwt_round_sat #(
    .IN_W  (SUM_W),
    .FRAC  (pCOEF_FRAC),
    .OUT_W (pODAT_W)
  ) u_rs (
    .din_i  (sum),
    .dout_o (rs_dat),
    .clip_o (rs_clip)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    mode_d  = mode_q;
    xl_d    = xl_q;
    xh_d    = xh_q;
    accl_d  = accl_q;
    acch_d  = acch_q;
    odat_d  = odat_q;
    oena_d  = 1'b0;
    osat_d  = 1'b0;
    oovr_d  = oovr_q | (strobe & (state_q != IDLE));
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = MAC_E;
          k_d     = '0;
          accl_d  = '0;
          acch_d  = '0;
          xl_d[0] = bus.idat_l;
          xh_d[0] = bus.idat_h;
          for (int i = 1; i < NH; i++) begin
            xl_d[i] = xl_q[i-1];
            xh_d[i] = xh_q[i-1];
          end
          unique case (1'b1)
            (bus.imode == 2'd1): mode_d = MODE_L;
            (bus.imode == 2'd2): mode_d = MODE_H;
            default:             mode_d = MODE_SUM;
          endcase
        end
      end
      MAC_E, MAC_O: begin
        accl_d = accl_q + ACC_W'(prod_l);
        acch_d = acch_q + ACC_W'(prod_h);
        k_d    = k_q + KW'(1);
        if (k_last) begin
          k_d     = '0;
          state_d = (state_q == MAC_E) ? OUT_E : OUT_O;
        end
      end
      OUT_E, OUT_O: begin
        state_d = (state_q == OUT_E) ? MAC_O : IDLE;
        accl_d  = '0;
        acch_d  = '0;
        odat_d  = rs_dat;
        oena_d  = 1'b1;
        osat_d  = rs_clip;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q <= IDLE;
      k_q     <= '0;
      mode_q  <= MODE_SUM;
      for (int i = 0; i < NH; i++) begin
        xl_q[i] <= '0;
        xh_q[i] <= '0;
      end
      accl_q  <= '0;
      acch_q  <= '0;
      odat_q  <= '0;
      oena_q  <= 1'b0;
      osat_q  <= 1'b0;
      oovr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      xl_q    <= xl_d;
      xh_q    <= xh_d;
      accl_q  <= accl_d;
      acch_q  <= acch_d;
      odat_q  <= odat_d;
      oena_q  <= oena_d;
      osat_q  <= osat_d;
      oovr_q  <= oovr_d;
    end
  end

  assign bus.odat  = odat_q;
  assign bus.oena  = oena_q;
  assign bus.osat  = osat_q;
  assign bus.obusy = (state_q != IDLE);
  assign bus.oovr  = oovr_q;

endmodule

// File: tb/tb_dwt_synth_stage.sv
// tb_dwt_synth_stage: directed vectors for the synthesis
// stage, plus a narrow-output instance to reach clipping.
module tb_dwt_synth_stage;

  logic iclk = 1'b0;
  logic irst;

  always #5 iclk = ~iclk;

  dwt_synth_stage_if #(.pIDAT_W(18), .pODAT_W(20)) bus ();
  dwt_synth_stage_if #(.pIDAT_W(18), .pODAT_W(18)) bus_n ();

  dwt_synth_stage dut (
    .iclk (iclk),
    .irst (irst),
    .bus  (bus)
  );

  dwt_synth_stage #(.pODAT_W(18)) dut_n (
    .iclk (iclk),
    .irst (irst),
    .bus  (bus_n)
  );

  assign bus_n.iclk_ena = bus.iclk_ena;
  assign bus_n.iena     = bus.iena;
  assign bus_n.idat_l   = bus.idat_l;
  assign bus_n.idat_h   = bus.idat_h;
  assign bus_n.imode    = bus.imode;

  int cl [12] = '{7309, 32415, 49226, 20660, -14829, -8505,
                  6389, 1803, -2070, 36, 313, -71};
  int ch [12] = '{-71, -314, 36, 2069, 1803, -6390,
                  -8505, 14828, 20660, -49227, 32415, -7310};
  int imp1 [12] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  int n_chk = 0;
  int n_err = 0;

  longint ev_dat, od_dat, nev_dat, nod_dat;
  logic   ev_sat, od_sat, nev_sat, nod_sat;
  int     ev_cyc, od_cyc, n_pulse, busy_bad;

  localparam int NP = 32;
  int     a [NP];
  int     d [NP];
  longint y [2*NP];

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    irst         = 1'b1;
    bus.iclk_ena = 1'b0;
    bus.iena     = 1'b0;
    repeat (2) @(posedge iclk);
    #1;
    irst = 1'b0;
  endtask

  // Present a pair in cycle 0 and watch cycles 1..16.
  task automatic run_pair(input int l, input int h, input int m,
                          input int drop_at = 0,
                          input int rst_at = 0);
    n_pulse  = 0;
    busy_bad = 0;
    ev_cyc   = -1;
    od_cyc   = -1;
    ev_dat   = -1234567;
    od_dat   = -1234567;
    nev_dat  = -1234567;
    nod_dat  = -1234567;
    bus.iclk_ena = 1'b1;
    bus.iena     = 1'b1;
    bus.idat_l   = 18'(l);
    bus.idat_h   = 18'(h);
    bus.imode    = 2'(m);
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(posedge iclk);
      #1;
      bus.iclk_ena = 1'b0;
      bus.iena     = 1'b0;
      if (cyc == drop_at) begin
        bus.iclk_ena = 1'b1;
        bus.iena     = 1'b1;
        bus.idat_l   = 18'sd99999;
        bus.idat_h   = 18'sd5000;
      end
      irst = (cyc == rst_at);
      if (rst_at > 0 && cyc == rst_at + 1) begin
        check("rst_odat", bus.odat, 0);
        check("rst_oena", bus.oena, 0);
        check("rst_osat", bus.osat, 0);
        check("rst_obusy", bus.obusy, 0);
        check("rst_oovr", bus.oovr, 0);
      end
      if (bus.obusy !== (cyc <= 14)) busy_bad++;
      if (bus.oena) begin
        n_pulse++;
        if (n_pulse == 1) begin
          ev_cyc  = cyc;
          ev_dat  = bus.odat;
          ev_sat  = bus.osat;
          nev_dat = bus_n.odat;
          nev_sat = bus_n.osat;
        end else begin
          od_cyc  = cyc;
          od_dat  = bus.odat;
          od_sat  = bus.osat;
          nod_dat = bus_n.odat;
          nod_sat = bus_n.osat;
        end
      end
    end
  endtask

  task automatic expect_pair(input string tag, input longint e,
                             input longint o);
    check({tag, "_np"}, n_pulse, 2);
    check({tag, "_e"}, ev_dat, e);
    check({tag, "_o"}, od_dat, o);
  endtask

  function automatic longint xr(input int i);
    return (i < 0) ? 0 : 16 * i;
  endfunction

  // Direct-form upsample-and-convolve reference.
  function automatic longint synth_ref(input int n);
    longint s;
    int j;
    s = 0;
    for (int m = 0; m < NP; m++) begin
      j = n - 2 * m;
      if (j >= 0 && j < 12)
        s += longint'(cl[j]) * a[m] + longint'(ch[j]) * d[m];
    end
    return (s + 32768) >>> 16;
  endfunction

  initial begin
    longint sa, sd, err;
    irst         = 1'b1;
    bus.iclk_ena = 1'b0;
    bus.iena     = 1'b0;
    bus.idat_l   = '0;
    bus.idat_h   = '0;
    bus.imode    = '0;
    repeat (3) @(posedge iclk);
    #1;
    check("rst0_odat", bus.odat, 0);
    check("rst0_oena", bus.oena, 0);
    check("rst0_osat", bus.osat, 0);
    check("rst0_obusy", bus.obusy, 0);
    check("rst0_oovr", bus.oovr, 0);
    irst = 1'b0;

    for (int p = 0; p < 6; p++) begin
      run_pair((p == 0) ? 1 : 0, 0, 0);
      if (p == 0) begin
        check("lat_even", ev_cyc, 8);
        check("lat_odd", od_cyc, 15);
        check("busy_win", busy_bad, 0);
      end
      expect_pair("imp1", imp1[2*p], imp1[2*p+1]);
    end
    for (int p = 0; p < 6; p++) begin
      run_pair((p == 0) ? 65536 : 0, 0, 0);
      expect_pair("imp64k", cl[2*p], cl[2*p+1]);
      check("imp64k_sat", ev_sat | od_sat, 0);
    end
    check("no_ovr", bus.oovr, 0);

    do_reset();
    for (int p = 0; p < 6; p++) begin
      run_pair((p == 0) ? 65536 : 0, (p == 0) ? 12345 : 777, 1);
      expect_pair("modeL", cl[2*p], cl[2*p+1]);
    end
    do_reset();
    for (int p = 0; p < 6; p++) begin
      run_pair((p == 0) ? 1234 : 55, (p == 0) ? 65536 : 0, 2);
      expect_pair("modeH", ch[2*p], ch[2*p+1]);
    end
    do_reset();
    run_pair(65536, 65536, 3);
    expect_pair("mode3", 7238, 32101);

    do_reset();
    for (int p = 0; p < 6; p++) run_pair(131071, 131071, 0);
    expect_pair("satp", 185351, -12);
    check("satp_osat_e", ev_sat, 0);
    check("satp_n_e", nev_dat, 131071);
    check("satp_n_sat_e", nev_sat, 1);
    check("satp_n_o", nod_dat, -12);
    check("satp_n_sat_o", nod_sat, 0);
    for (int p = 0; p < 6; p++) run_pair(-131072, -131072, 0);
    expect_pair("satn", -185352, 12);
    check("satn_n_e", nev_dat, -131072);
    check("satn_n_sat_e", nev_sat, 1);
    check("satn_n_o", nod_dat, 12);
    check("satn_n_sat_o", nod_sat, 0);

    do_reset();
    run_pair(65536, 0, 0, 5);
    expect_pair("ovr0", cl[0], cl[1]);
    check("ovr_set", bus.oovr, 1);
    run_pair(0, 0, 0);
    expect_pair("ovr1", cl[2], cl[3]);
    check("ovr_sticky", bus.oovr, 1);

    run_pair(65536, 0, 0, 0, 4);
    check("rst_mid_np", n_pulse, 0);
    run_pair(65536, 0, 0);
    expect_pair("post_rst0", cl[0], cl[1]);
    run_pair(0, 0, 0);
    expect_pair("post_rst1", cl[2], cl[3]);

    // Ramp through an orthogonal analysis bank, then rebuild.
    for (int m = 0; m < NP; m++) begin
      sa = 0;
      sd = 0;
      for (int j = 0; j < 12; j++) begin
        sa += longint'(cl[11-j]) * xr(2 * m - j);
        sd += longint'(ch[11-j]) * xr(2 * m - j);
      end
      a[m] = int'((sa + 32768) >>> 16);
      d[m] = int'((sd + 32768) >>> 16);
    end
    do_reset();
    for (int p = 0; p < NP; p++) begin
      run_pair(a[p], d[p], 0);
      check("pr_np", n_pulse, 2);
      y[2*p]   = ev_dat;
      y[2*p+1] = od_dat;
    end
    for (int n = 0; n < 2 * NP; n++) begin
      check("pr_ref", y[n], synth_ref(n));
      if (n >= 24) begin
        err = y[n] - xr(n - 11);
        check("pr_err", (err >= -1 && err <= 1) ? 0 : err, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
